// File: rtl/apb_slave_regfile.sv
// APB slave register file: read-only ID at word 0, DEPTH-1 read/write words, WAIT_CYCLES wait states.
// Optional byte strobes (pstrb port) are enabled by defining APB_SLAVE_PSTRB_EN.
module apb_slave_regfile #(
   parameter int unsigned            DATA_WIDTH  = 32,
   parameter int unsigned            ADDR_WIDTH  = 12,
   parameter int unsigned            DEPTH       = 16,
   parameter int unsigned            WAIT_CYCLES = 2,
   parameter logic [DATA_WIDTH-1:0]  ID_VALUE    = 32'hA9B0_0001
) (
   input  logic                      pclk,
   input  logic                      rst,
   input  logic                      psel,
   input  logic                      penable,
   input  logic                      pwrite,
   input  logic [ADDR_WIDTH-1:0]     paddr,
   input  logic [DATA_WIDTH-1:0]     pwdata,
`ifdef APB_SLAVE_PSTRB_EN
   input  logic [DATA_WIDTH/8-1:0]   pstrb,
`endif
   output logic [DATA_WIDTH-1:0]     prdata,
   output logic                      pready,
   output logic                      pslverr
);

   localparam int unsigned IDXW      = $clog2(DEPTH);
   localparam int unsigned NB        = DATA_WIDTH / 8;
   localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    write_q, write_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic                    pready_q, pready_d;
   logic                    pslverr_q, pslverr_d;
   logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
   logic [DATA_WIDTH-1:0]   regs_q [DEPTH];
   logic [DATA_WIDTH-1:0]   regs_d [DEPTH];
   logic [NB-1:0]           wr_strb;

`ifdef APB_SLAVE_PSTRB_EN
   logic [NB-1:0]           strb_q, strb_d;
   assign wr_strb = strb_q;
`else
   assign wr_strb = '1;
`endif

   // Decode the live bus in IDLE (zero-wait RESP is entered straight from setup),
   // otherwise the latched request.
   logic [ADDR_WIDTH-1:0]   acc_addr;
   logic                    acc_write;
   logic [IDXW-1:0]         acc_idx;
   logic                    acc_err;
   logic                    load_resp;

   always_comb begin
      if (state_q == S_IDLE) begin
         acc_addr  = paddr;
         acc_write = pwrite;
      end else begin
         acc_addr  = addr_q;
         acc_write = write_q;
      end
      acc_idx = acc_addr[IDXW+1:2];
      acc_err = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (IDXW + 2)) != '0) ||
                (acc_write && (acc_idx == '0));
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      write_d   = write_q;
      wdata_d   = wdata_q;
`ifdef APB_SLAVE_PSTRB_EN
      strb_d    = strb_q;
`endif
      regs_d    = regs_q;
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      prdata_d  = '0;
      load_resp = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (psel && !penable) begin
               addr_d  = paddr;
               write_d = pwrite;
               wdata_d = pwdata;
`ifdef APB_SLAVE_PSTRB_EN
               strb_d  = pstrb;
`endif
               if (WAIT_CYCLES == 0) begin
                  state_d   = S_RESP;
                  load_resp = 1'b1;
               end else begin
                  cnt_d   = WAIT_INIT;
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (!psel) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_d   = S_RESP;
                  load_resp = 1'b1;
               end
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
            if (psel && acc_write && !acc_err) begin
               for (int unsigned b = 0; b < NB; b++) begin
                  if (wr_strb[b]) regs_d[acc_idx][8*b +: 8] = wdata_q[8*b +: 8];
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Response outputs are registered on entry to RESP so they hold for that one cycle.
      if (load_resp) begin
         pready_d  = 1'b1;
         pslverr_d = acc_err;
         if (!acc_write && !acc_err) prdata_d = (acc_idx == '0) ? ID_VALUE : regs_q[acc_idx];
      end
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
`ifdef APB_SLAVE_PSTRB_EN
         strb_q    <= '0;
`endif
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         write_q   <= write_d;
         wdata_q   <= wdata_d;
`ifdef APB_SLAVE_PSTRB_EN
         strb_q    <= strb_d;
`endif
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q  <= prdata_d;
         regs_q    <= regs_d;
      end
   end

   assign pready  = pready_q;
   assign pslverr = pslverr_q;
   assign prdata  = prdata_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: two instances (2 and 0 wait states) on a shared bus.
// Byte-strobe checks run only when APB_SLAVE_PSTRB_EN is defined.
module tb_apb_slave_regfile;

   localparam logic [31:0] ID = 32'hA9B0_0001;

   logic        pclk = 1'b0;
   logic        rst  = 1'b1;
   logic        psel2 = 1'b0, psel0 = 1'b0;
   logic        penable = 1'b0, pwrite = 1'b0;
   logic [11:0] paddr = '0;
   logic [31:0] pwdata = '0;
`ifdef APB_SLAVE_PSTRB_EN
   logic [3:0]  pstrb = 4'hF;
`endif
   logic [31:0] prdata2, prdata0;
   logic        pready2, pready0, pslverr2, pslverr0;

   int n_checks = 0;
   int n_errors = 0;

   always #5 pclk = ~pclk;

   apb_slave_regfile #(
      .DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(16), .WAIT_CYCLES(2), .ID_VALUE(ID)
   ) dut2 (
      .pclk(pclk), .rst(rst), .psel(psel2), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata),
`ifdef APB_SLAVE_PSTRB_EN
      .pstrb(pstrb),
`endif
      .prdata(prdata2), .pready(pready2), .pslverr(pslverr2)
   );

   apb_slave_regfile #(
      .DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(16), .WAIT_CYCLES(0), .ID_VALUE(ID)
   ) dut0 (
      .pclk(pclk), .rst(rst), .psel(psel0), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata),
`ifdef APB_SLAVE_PSTRB_EN
      .pstrb(pstrb),
`endif
      .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
   );

   typedef struct {
      bit          use0;
      bit          wr;
      logic [11:0] addr;
      logic [31:0] data;
      logic [31:0] exp_rd;
      bit          exp_err;
      int          exp_waits;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic mk(input bit use0, input bit wr, input logic [11:0] addr, input logic [31:0] data,
                     input logic [31:0] exp_rd, input bit exp_err, input int exp_waits);
      vec_t v;
      v.use0 = use0; v.wr = wr; v.addr = addr; v.data = data;
      v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_waits = exp_waits;
      vecs.push_back(v);
   endtask

   // One APB transfer; returns right after pready is seen, so a following call is back-to-back.
   task automatic xfer(input bit use0, input bit wr, input logic [11:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, output logic [31:0] rd, output logic err, output int waits);
      @(posedge pclk); #1;
      chk("pready_low_at_setup", {31'b0, (use0 ? pready0 : pready2)}, 32'd0);
      psel0 = use0; psel2 = !use0; penable = 1'b0;
      pwrite = wr; paddr = addr; pwdata = data;
`ifdef APB_SLAVE_PSTRB_EN
      pstrb = strb;
`else
      if (strb != 4'hF) $display("note: strobe %h ignored in full-word build", strb);
`endif
      @(posedge pclk); #1;
      penable = 1'b1;
      waits = 0;
      while (!(use0 ? pready0 : pready2) && waits < 20) begin
         @(posedge pclk); #1;
         waits++;
      end
      if (waits >= 20) begin
         n_checks++;
         n_errors++;
         $display("FAIL pready_timeout: addr %h never completed", addr);
      end
      rd  = use0 ? prdata0 : prdata2;
      err = use0 ? pslverr0 : pslverr2;
   endtask

   task automatic bus_idle();
      @(posedge pclk); #1;
      psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      logic        err;
      int          waits;

      // WAIT_CYCLES=2 instance
      mk(0, 1, 12'h004, 32'h0000_0005, 32'h0,          0, 2);
      mk(0, 0, 12'h004, 32'h0,          32'h0000_0005, 0, 2);
      mk(0, 0, 12'h000, 32'h0,          ID,            0, 2);
      mk(0, 1, 12'h000, 32'hDEAD_BEEF,  32'h0,         1, 2);
      mk(0, 0, 12'h000, 32'h0,          ID,            0, 2);
      mk(0, 1, 12'h006, 32'h0000_0077,  32'h0,         1, 2);
      mk(0, 0, 12'h006, 32'h0,          32'h0,         1, 2);
      mk(0, 1, 12'h040, 32'h0000_0099,  32'h0,         1, 2);
      mk(0, 1, 12'h044, 32'h0000_0099,  32'h0,         1, 2);
      mk(0, 0, 12'h040, 32'h0,          32'h0,         1, 2);
      mk(0, 0, 12'h004, 32'h0,          32'h0000_0005, 0, 2);
      mk(0, 1, 12'h03C, 32'hCAFE_F00D,  32'h0,         0, 2);
      mk(0, 0, 12'h03C, 32'h0,          32'hCAFE_F00D, 0, 2);
      mk(0, 0, 12'h008, 32'h0,          32'h0,         0, 2);
      // WAIT_CYCLES=0 instance, back-to-back
      mk(1, 1, 12'h000, 32'd1, 32'h0, 1, 0);
      mk(1, 1, 12'h004, 32'd2, 32'h0, 0, 0);
      mk(1, 1, 12'h008, 32'd3, 32'h0, 0, 0);
      mk(1, 1, 12'h00C, 32'd4, 32'h0, 0, 0);
      mk(1, 0, 12'h000, 32'h0, ID,    0, 0);
      mk(1, 0, 12'h004, 32'h0, 32'd2, 0, 0);
      mk(1, 0, 12'h008, 32'h0, 32'd3, 0, 0);
      mk(1, 0, 12'h00C, 32'h0, 32'd4, 0, 0);

      repeat (3) @(posedge pclk);
      #1;
      chk("rst_pready2",  {31'b0, pready2},  32'd0);
      chk("rst_pslverr2", {31'b0, pslverr2}, 32'd0);
      chk("rst_prdata2",  prdata2,           32'd0);
      chk("rst_pready0",  {31'b0, pready0},  32'd0);
      chk("rst_pslverr0", {31'b0, pslverr0}, 32'd0);
      chk("rst_prdata0",  prdata0,           32'd0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         xfer(vecs[i].use0, vecs[i].wr, vecs[i].addr, vecs[i].data, 4'hF, rd, err, waits);
         chk($sformatf("vec%0d_prdata", i),  rd,                 vecs[i].exp_rd);
         chk($sformatf("vec%0d_pslverr", i), {31'b0, err},       {31'b0, vecs[i].exp_err});
         chk($sformatf("vec%0d_waits", i),   32'(waits),         32'(vecs[i].exp_waits));
      end
      bus_idle();

      // psel dropped during WAIT: no commit, no pready
      @(posedge pclk); #1;
      psel2 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h00C; pwdata = 32'h0000_0055;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(posedge pclk); #1;
      psel2 = 1'b0; penable = 1'b0;
      repeat (3) begin
         @(posedge pclk); #1;
         chk("abort_pready", {31'b0, pready2}, 32'd0);
      end
      xfer(0, 0, 12'h00C, 32'h0, 4'hF, rd, err, waits);
      chk("abort_readback", rd, 32'h0);
      bus_idle();

      // reset during WAIT of a write to 0x008
      @(posedge pclk); #1;
      psel2 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h008; pwdata = 32'h0000_ABCD;
      @(posedge pclk); #1;
      penable = 1'b1;
      rst = 1'b1;
      @(posedge pclk); #1;
      chk("rstmid_pready", {31'b0, pready2}, 32'd0);
      rst = 1'b0; psel2 = 1'b0; penable = 1'b0;
      repeat (3) begin
         @(posedge pclk); #1;
         chk("rstmid_pready_after", {31'b0, pready2}, 32'd0);
      end
      xfer(0, 0, 12'h008, 32'h0, 4'hF, rd, err, waits);
      chk("rstmid_readback", rd, 32'h0);
      chk("rstmid_readback_err", {31'b0, err}, 32'd0);
      xfer(0, 0, 12'h004, 32'h0, 4'hF, rd, err, waits);
      chk("rst_cleared_reg1", rd, 32'h0);
      bus_idle();

`ifdef APB_SLAVE_PSTRB_EN
      xfer(0, 1, 12'h008, 32'hFFFF_FFFF, 4'hF, rd, err, waits);
      xfer(0, 1, 12'h008, 32'h1234_5678, 4'b0101, rd, err, waits);
      chk("strb_write_err", {31'b0, err}, 32'd0);
      xfer(0, 0, 12'h008, 32'h0, 4'hF, rd, err, waits);
      chk("strb_readback", rd, 32'hFF34_FF78);
      xfer(0, 1, 12'h008, 32'h0000_0000, 4'b0000, rd, err, waits);
      chk("strb_zero_err", {31'b0, err}, 32'd0);
      xfer(0, 0, 12'h008, 32'h0, 4'hF, rd, err, waits);
      chk("strb_zero_readback", rd, 32'hFF34_FF78);
      bus_idle();
`endif

      repeat (2) @(posedge pclk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/apb_slave_regfile.md
APB_SLAVE_REGFILE -- requirements
Module: apb_slave_regfile

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning pwdata/prdata width (multiple of 8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, meaning paddr width.
REQ-003 SHALL have parameter DEPTH, default 16, meaning number of word registers (power of 2, at least 2).
REQ-004 SHALL have parameter WAIT_CYCLES, default 2, meaning wait states inserted per transfer (0..15).
REQ-005 SHALL have parameter ID_VALUE, default 32'hA9B0_0001, meaning the constant read at register 0.
REQ-006 SHALL have port pclk  input  1  sole clock, all logic on its rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port psel  input  1  APB select.
REQ-009 SHALL have port penable  input  1  APB access phase.
REQ-010 SHALL have port pwrite  input  1  1 = write, 0 = read.
REQ-011 SHALL have port paddr  input  ADDR_WIDTH  byte address.
REQ-012 SHALL have port pwdata  input  DATA_WIDTH  write data.
REQ-013 SHALL have port pstrb  input  DATA_WIDTH/8  byte write strobes (present only under APB_SLAVE_PSTRB_EN).
REQ-014 SHALL have port prdata  output  DATA_WIDTH  read data.
REQ-015 SHALL have port pready  output  1  transfer complete.
REQ-016 SHALL have port pslverr  output  1  transfer error, valid only with pready.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, RESP, with all outputs driven from registered state and registers.
REQ-018 In IDLE with psel=1 and penable=0, the block SHALL latch paddr, pwrite, pwdata (and pstrb), then go to RESP if WAIT_CYCLES=0, else load counter=WAIT_CYCLES and go to WAIT.
REQ-019 In WAIT, the counter SHALL decrement each cycle; on the cycle the counter equals 1, the FSM SHALL go to RESP, giving exactly WAIT_CYCLES access cycles with pready=0.
REQ-020 In RESP, pready SHALL be 1 for exactly one cycle; the FSM SHALL return to IDLE the next cycle; write commit occurs at this clock edge.
REQ-021 Minimum transfer SHALL be 2 cycles (setup + access); back-to-back transfers SHALL be accepted with the next SETUP in the cycle after RESP, with no idle gap.
REQ-022 Word index SHALL be paddr[log2(DEPTH)+1:2]; paddr bits above that index SHALL be non-zero only for out-of-range accesses.
REQ-023 pslverr SHALL be 1 in RESP if paddr[1:0]!=0, paddr >= DEPTH*4, or the access is a write to register 0; such writes SHALL leave all registers unchanged.
REQ-024 A read SHALL drive prdata with the latched register value (ID_VALUE for index 0) only while pready=1 and no error; otherwise prdata SHALL be 0.
REQ-025 If psel drops during WAIT or RESP, the FSM SHALL return to IDLE without committing and with pready=0 (aborted transfer).
REQ-026 psel with penable=1 in IDLE (protocol violation) SHALL be ignored.

Reset
REQ-027 While rst=1 at a clock edge: FSM SHALL go to IDLE, counter to 0, registers 1..DEPTH-1 to 0, and pready, pslverr, prdata to 0.
REQ-028 Reset asserted mid-transfer SHALL abort the transfer with no register write.

Configuration
REQ-029 With APB_SLAVE_PSTRB_EN defined, the pstrb port SHALL exist and a write SHALL update only the bytes whose strobe bit is 1; a write with pstrb=0 SHALL complete with pslverr=0 and no change.
REQ-030 Without APB_SLAVE_PSTRB_EN, the pstrb port SHALL be absent and every error-free write SHALL update the full word.

Verification
REQ-031 SHALL test: WAIT_CYCLES=2, write 0x0000_0005 to 0x004, then read 0x004 -> each transfer shows 2 pready=0 access cycles then pready=1, and the read returns 0x0000_0005 with pslverr=0.
REQ-032 SHALL test: read 0x000 -> prdata=ID_VALUE; write 0x000 -> pslverr=1 and a subsequent read still returns ID_VALUE.
REQ-033 SHALL test: accesses to 0x006 (unaligned) and 0x040 (out of range, DEPTH=16) -> pslverr=1, prdata=0, no register changed.
REQ-034 SHALL test: WAIT_CYCLES=0, four back-to-back writes to 0x0/0x4/0x8/0xC with data i+1 -> each completes in 2 cycles; readback matches, except 0x0, which errors.
REQ-035 SHALL test: assert rst during WAIT of a write to 0x008 -> pready stays 0 and a read of 0x008 after reset returns 0.
REQ-036 SHALL test, with APB_SLAVE_PSTRB_EN: write 0xFFFF_FFFF to 0x008, then write 0x1234_5678 with pstrb=4'b0101 -> read returns 0xFF34_FF78.
